// File: rtl/fladdsub_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fladdsub_pipe_pkg
// Shared FP32 constants, field helpers and pipeline stage records used by the
// butterfly add/sub pipeline (fladdsub_pipe) and its leading-zero counter
// (fl_lzc).
// No ports: package only.
// -----------------------------------------------------------------------------
package fladdsub_pipe_pkg;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    // Aligned mantissa: hidden 1 + 23 fraction bits + guard/round/sticky.
    localparam int MAN_EXT_W = 27;
    // Adder width: aligned mantissa plus one carry bit.
    localparam int SUM_W     = 28;

    function automatic logic fp_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] f);
        return f[22:0];
    endfunction

    function automatic logic [31:0] fp_signed_inf(input logic s);
        return s ? FP_NEG_INF : FP_POS_INF;
    endfunction

    // Unpack/align results, registered at the end of stage 1.
    typedef struct packed {
        logic                 special;   // result is fully decided by spec_val
        logic [31:0]          spec_val;
        logic                 zero_neg;  // (-0)+(-0): exact zero keeps the minus sign
        logic                 sign;      // sign of the larger-magnitude operand
        logic                 eff_sub;   // operand signs differ after the op_sub flip
        logic [7:0]           exp;       // exponent of the larger operand
        logic [MAN_EXT_W-1:0] big_m;
        logic [MAN_EXT_W-1:0] small_m;   // already shifted into alignment
    } s1_t;

    // Add results, registered at the end of stage 2.
    typedef struct packed {
        logic             special;
        logic [31:0]      spec_val;
        logic             zero_neg;
        logic             sign;
        logic [7:0]       exp;
        logic [SUM_W-1:0] sum;
    } s2_t;

endpackage

// File: rtl/fl_lzc.sv
// -----------------------------------------------------------------------------
// fl_lzc
// Combinational leading-zero counter over the 28-bit mantissa sum. Intended to
// be reused by later fladd stages.
// Ports:
//   i_data  [27:0]  value to scan, bit 27 is the most significant
//   o_count [4:0]   number of zeros above the first 1 (28 when i_data is 0)
// -----------------------------------------------------------------------------
module fl_lzc
    import fladdsub_pipe_pkg::*;
(
    input  logic [SUM_W-1:0] i_data,
    output logic [4:0]       o_count
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        o_count = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (i_data[i]) begin
                o_count = 5'(SUM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fladdsub_pipe.sv
// -----------------------------------------------------------------------------
// fladdsub_pipe
// Three-stage pipelined FP32 adder/subtractor for the butterfly datapath
// (X = A + W*B, Y = A - W*B with W*B arriving from flmult). One operation per
// clock, valid/ready on both sides, tag carried alongside each operation.
//   S1: unpack, flush subnormals, detect specials, swap, align small operand
//   S2: 28-bit magnitude add or subtract
//   S3: normalize, round, overflow/underflow/zero handling
// Build option:
//   FLADD_ROUND_NEAREST_EN  defined -> round to nearest, ties to even
//                           undefined -> truncate toward zero
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, flushes every in-flight op
//   in_valid   operation present on a_in/b_in/op_sub/tag_in
//   in_ready   operation is accepted this cycle
//   a_in       operand A (FP32)
//   b_in       operand B (FP32)
//   op_sub     0: A+B, 1: A-B
//   tag_in     sideband tag, returned unchanged on tag_out
//   out_valid  result/tag_out hold a completed operation
//   out_ready  downstream takes the result this cycle
//   result     FP32 result
//   tag_out    tag of the operation on result
// -----------------------------------------------------------------------------
module fladdsub_pipe
    import fladdsub_pipe_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic             op_sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] tag_out
);

`ifdef FLADD_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    s1_t              r_s1;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    s2_t              r_s2;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_out_valid;
    logic [31:0]      r_result;
    logic [TAG_W-1:0] r_tag_out;

    // Global stall: every stage moves together whenever the output slot
    // is empty or being drained.
    logic w_adv;
    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign tag_out   = r_tag_out;

    // ------------------------------------------------------------------
    // S1: unpack / specials / swap / align
    // ------------------------------------------------------------------
    logic        w_a_sign, w_b_sign;
    logic [7:0]  w_a_exp, w_b_exp;
    logic [22:0] w_a_man, w_b_man;
    logic        w_a_zero, w_b_zero;
    logic        w_a_nan, w_b_nan;
    logic        w_a_inf, w_b_inf;
    logic [23:0] w_a_man24, w_b_man24;
    logic [30:0] w_a_mag, w_b_mag;
    logic        w_a_big;

    assign w_a_sign = fp_sign(a_in);
    assign w_b_sign = fp_sign(b_in) ^ op_sub;
    assign w_a_exp  = fp_exp(a_in);
    assign w_b_exp  = fp_exp(b_in);
    assign w_a_man  = fp_man(a_in);
    assign w_b_man  = fp_man(b_in);

    assign w_a_zero = (w_a_exp == 8'd0);
    assign w_b_zero = (w_b_exp == 8'd0);
    assign w_a_nan  = (w_a_exp == FP_EXP_MAX) && (w_a_man != 23'd0);
    assign w_b_nan  = (w_b_exp == FP_EXP_MAX) && (w_b_man != 23'd0);
    assign w_a_inf  = (w_a_exp == FP_EXP_MAX) && (w_a_man == 23'd0);
    assign w_b_inf  = (w_b_exp == FP_EXP_MAX) && (w_b_man == 23'd0);

    // Subnormals become signed zero: fraction dropped, no hidden bit.
    assign w_a_man24 = w_a_zero ? 24'd0 : {1'b1, w_a_man};
    assign w_b_man24 = w_b_zero ? 24'd0 : {1'b1, w_b_man};
    assign w_a_mag   = {w_a_exp, w_a_man24[22:0]};
    assign w_b_mag   = {w_b_exp, w_b_man24[22:0]};
    assign w_a_big   = (w_a_mag >= w_b_mag);

    logic                 w_big_sign;
    logic [7:0]           w_big_exp, w_small_exp;
    logic [23:0]          w_big_man24, w_small_man24;
    logic [7:0]           w_shift;
    logic [4:0]           w_sh5;
    logic [MAN_EXT_W-1:0] w_small_ext, w_small_shr, w_lost_mask;
    logic [MAN_EXT_W-1:0] w_small_aligned;

    assign w_big_sign    = w_a_big ? w_a_sign  : w_b_sign;
    assign w_big_exp     = w_a_big ? w_a_exp   : w_b_exp;
    assign w_small_exp   = w_a_big ? w_b_exp   : w_a_exp;
    assign w_big_man24   = w_a_big ? w_a_man24 : w_b_man24;
    assign w_small_man24 = w_a_big ? w_b_man24 : w_a_man24;

    // Magnitude ordering guarantees w_big_exp >= w_small_exp.
    assign w_shift     = w_big_exp - w_small_exp;
    assign w_sh5       = w_shift[4:0];
    assign w_small_ext = {w_small_man24, 3'b000};
    assign w_small_shr = w_small_ext >> w_sh5;
    assign w_lost_mask = (27'd1 << w_sh5) - 27'd1;

    // Bits shifted past the sticky position are OR-folded into bit 0.
    always_comb begin
        w_small_aligned = w_small_shr;
        if (w_shift >= 8'd27) begin
            w_small_aligned = {26'd0, |w_small_man24};
        end else begin
            w_small_aligned[0] = w_small_shr[0] | (|(w_small_ext & w_lost_mask));
        end
    end

    logic        w_special;
    logic [31:0] w_spec_val;

    always_comb begin
        w_special  = 1'b0;
        w_spec_val = FP_QNAN;
        if (w_a_nan || w_b_nan) begin
            w_special  = 1'b1;
            w_spec_val = FP_QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_special  = 1'b1;
            w_spec_val = (w_a_sign != w_b_sign) ? FP_QNAN : fp_signed_inf(w_a_sign);
        end else if (w_a_inf) begin
            w_special  = 1'b1;
            w_spec_val = fp_signed_inf(w_a_sign);
        end else if (w_b_inf) begin
            w_special  = 1'b1;
            w_spec_val = fp_signed_inf(w_b_sign);
        end
    end

    s1_t w_s1_next;

    always_comb begin
        w_s1_next          = '0;
        w_s1_next.special  = w_special;
        w_s1_next.spec_val = w_spec_val;
        w_s1_next.zero_neg = w_a_zero & w_b_zero & w_a_sign & w_b_sign;
        w_s1_next.sign     = w_big_sign;
        w_s1_next.eff_sub  = w_a_sign ^ w_b_sign;
        w_s1_next.exp      = w_big_exp;
        w_s1_next.big_m    = {w_big_man24, 3'b000};
        w_s1_next.small_m  = w_small_aligned;
    end

    // ------------------------------------------------------------------
    // S2: magnitude add/subtract (big >= small, so never negative)
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] w_sum;
    s2_t              w_s2_next;

    assign w_sum = r_s1.eff_sub ? ({1'b0, r_s1.big_m} - {1'b0, r_s1.small_m})
                                : ({1'b0, r_s1.big_m} + {1'b0, r_s1.small_m});

    always_comb begin
        w_s2_next          = '0;
        w_s2_next.special  = r_s1.special;
        w_s2_next.spec_val = r_s1.spec_val;
        w_s2_next.zero_neg = r_s1.zero_neg;
        w_s2_next.sign     = r_s1.sign;
        w_s2_next.exp      = r_s1.exp;
        w_s2_next.sum      = w_sum;
    end

    // ------------------------------------------------------------------
    // S3: normalize / round / pack
    // ------------------------------------------------------------------
    logic [4:0]       w_lzc;
    logic [SUM_W-1:0] w_norm;
    logic             w_sum_zero;
    logic [22:0]      w_man;
    logic             w_g, w_r, w_s;
    logic             w_round_up;
    logic [23:0]      w_man_rnd;
    logic signed [9:0] w_exp_norm, w_exp_rnd;
    logic [31:0]      w_s3_result;

    fl_lzc u_lzc (
        .i_data  (r_s2.sum),
        .o_count (w_lzc)
    );

    // Shifting left by the full leading-zero count puts the hidden bit at
    // bit 27. A carry-out (lzc=0) is therefore the right-shift-by-one case
    // and falls out of the same exponent formula: exp + 1 - lzc.
    assign w_norm     = r_s2.sum << w_lzc;
    assign w_sum_zero = ~w_norm[27];
    assign w_man      = w_norm[26:4];
    assign w_g        = w_norm[3];
    assign w_r        = w_norm[2];
    assign w_s        = |w_norm[1:0];
    assign w_exp_norm = $signed({2'b00, r_s2.exp}) + 10'sd1 - $signed({5'b00000, w_lzc});

    // Truncation never increments; nearest-even rounds up above the halfway
    // point, or exactly at it when the LSB is odd.
    assign w_round_up = ROUND_NEAREST & w_g & (w_r | w_s | w_man[0]);

    // A carry out of the 23-bit fraction leaves it at zero and bumps the exponent.
    assign w_man_rnd = {1'b0, w_man} + {23'd0, w_round_up};
    assign w_exp_rnd = w_exp_norm + $signed({9'd0, w_man_rnd[23]});

    always_comb begin
        w_s3_result = {r_s2.sign, w_exp_rnd[7:0], w_man_rnd[22:0]};
        if (r_s2.special) begin
            w_s3_result = r_s2.spec_val;
        end else if (w_sum_zero) begin
            w_s3_result = {r_s2.zero_neg, 31'd0};
        end else if (w_exp_rnd >= 10'sd255) begin
            w_s3_result = fp_signed_inf(r_s2.sign);
        end else if (w_exp_rnd <= 10'sd0) begin
            w_s3_result = {r_s2.sign, 31'd0};
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2        <= '0;
            r_s2_tag    <= '0;
            r_out_valid <= 1'b0;
            r_result    <= 32'h0;
            r_tag_out   <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s1        <= w_s1_next;
            r_s1_tag    <= tag_in;
            r_s2_valid  <= r_s1_valid;
            r_s2        <= w_s2_next;
            r_s2_tag    <= r_s1_tag;
            r_out_valid <= r_s2_valid;
            // Bubbles leave the last delivered result on the port.
            if (r_s2_valid) begin
                r_result  <= w_s3_result;
                r_tag_out <= r_s2_tag;
            end
        end
    end

endmodule
